// File: rtl/plc_axil_regs.sv
// AXI4-Lite register file for the PLC core: four R/W config words with per-slot
// update strobes, two read-only status words, and two reserved slots reading zero.
module plc_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3,
  output logic [3:0]                      cfg_upd,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   sts_lost_cnt,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   sts_frame_cnt
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic          aw_latched_reg, aw_latched_next;
  logic          w_latched_reg, w_latched_next;
  logic [2:0]    aw_slot_reg;
  logic [DW-1:0] w_data_reg;
  logic [SW-1:0] w_strb_reg;
  logic          awready_reg, wready_reg, bvalid_reg, bvalid_next;
  logic          arready_reg, rvalid_reg, rvalid_next;
  logic [DW-1:0] rdata_reg, rd_mux;
  logic [3:0]    cfg_upd_reg, cfg_upd_next;
  logic [DW-1:0] cfg_val [0:3];

  logic          aw_hs, w_hs, ar_hs, wr_exec;
  logic [2:0]    wr_slot;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;

  assign aw_hs = S_AXI_AWVALID && awready_reg;
  assign w_hs  = S_AXI_WVALID && wready_reg;
  assign ar_hs = S_AXI_ARVALID && arready_reg;

  // A beat handshaking this cycle counts as available, so a write whose later
  // beat arrives in cycle N is committed on the edge that ends cycle N.
  assign wr_exec = (aw_latched_reg || aw_hs) && (w_latched_reg || w_hs);
  assign wr_slot = aw_latched_reg ? aw_slot_reg : S_AXI_AWADDR[4:2];
  assign wr_data = w_latched_reg ? w_data_reg : S_AXI_WDATA;
  assign wr_strb = w_latched_reg ? w_strb_reg : S_AXI_WSTRB;

  assign aw_latched_next = !wr_exec && (aw_latched_reg || aw_hs);
  assign w_latched_next  = !wr_exec && (w_latched_reg || w_hs);
  assign bvalid_next     = wr_exec || (bvalid_reg && !S_AXI_BREADY);
  assign rvalid_next     = ar_hs || (rvalid_reg && !S_AXI_RREADY);
  assign cfg_upd_next    = (wr_exec && !wr_slot[2]) ? (4'b0001 << wr_slot[1:0]) : 4'b0000;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_latched_reg <= 1'b0;
      w_latched_reg  <= 1'b0;
      aw_slot_reg    <= '0;
      w_data_reg     <= '0;
      w_strb_reg     <= '0;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      cfg_upd_reg    <= '0;
    end else begin
      aw_latched_reg <= aw_latched_next;
      w_latched_reg  <= w_latched_next;
      if (aw_hs) aw_slot_reg <= S_AXI_AWADDR[4:2];
      if (w_hs) begin
        w_data_reg <= S_AXI_WDATA;
        w_strb_reg <= S_AXI_WSTRB;
      end
      awready_reg <= !aw_latched_next && !bvalid_next;
      wready_reg  <= !w_latched_next && !bvalid_next;
      bvalid_reg  <= bvalid_next;
      cfg_upd_reg <= cfg_upd_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cfg
      logic [DW-1:0] val_reg;
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          val_reg <= '0;
        end else if (wr_exec && wr_slot == 3'(gi)) begin
          for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) val_reg[8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      assign cfg_val[gi] = val_reg;
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (S_AXI_ARADDR[4:2])
      3'd0:    rd_mux = cfg_val[0];
      3'd1:    rd_mux = cfg_val[1];
      3'd2:    rd_mux = cfg_val[2];
      3'd3:    rd_mux = cfg_val[3];
      3'd4:    rd_mux = sts_lost_cnt;
      3'd5:    rd_mux = sts_frame_cnt;
      default: rd_mux = '0;
    endcase
  end

  // RDATA is only reloaded on a handshake, which keeps it stable while RVALID waits.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      arready_reg <= !rvalid_next;
      rvalid_reg  <= rvalid_next;
      if (ar_hs) rdata_reg <= rd_mux;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = 2'b00;
  assign cfg_reg0      = cfg_val[0];
  assign cfg_reg1      = cfg_val[1];
  assign cfg_reg2      = cfg_val[2];
  assign cfg_reg3      = cfg_val[3];
  assign cfg_upd       = cfg_upd_reg;

endmodule

// File: tb/tb_plc_axil_regs.sv
// Randomized bench for plc_axil_regs against a word-array model of the register map
// with independent AW/W timing, B/R back-pressure, status sampling and mid-write reset.
module tb_plc_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [31:0] cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;
  logic [3:0]  cfg_upd;
  logic [31:0] sts_lost_cnt = '0;
  logic [31:0] sts_frame_cnt = '0;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_cfg [0:3];

  plc_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cfg_reg0(cfg_reg0), .cfg_reg1(cfg_reg1), .cfg_reg2(cfg_reg2), .cfg_reg3(cfg_reg3),
    .cfg_upd(cfg_upd), .sts_lost_cnt(sts_lost_cnt), .sts_frame_cnt(sts_frame_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] dut_cfg(input int k);
    case (k)
      0: return cfg_reg0;
      1: return cfg_reg1;
      2: return cfg_reg2;
      default: return cfg_reg3;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    int slot = int'(addr[4:2]);
    if (slot < 4) return model_cfg[slot];
    if (slot == 4) return sts_lost_cnt;
    if (slot == 5) return sts_frame_cnt;
    return 32'h0;
  endfunction

  task automatic check_all_cfg(input string tag);
    for (int k = 0; k < 4; k++) check(tag, dut_cfg(k), model_cfg[k]);
  endtask

  // aw_dly / w_dly: cycles before each beat is offered; b_dly: cycles BREADY stays low.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0;
    int slot = int'(addr[4:2]);
    logic [31:0] mask;
    logic [3:0] exp_upd;
    S_AXI_BREADY = 1'b0;
    while (!(aw_done && w_done) && cyc < 50) begin
      S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
      S_AXI_AWADDR  = addr;
      S_AXI_WVALID  = !w_done && cyc >= w_dly;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      if ((aw_done || hs_aw) && (w_done || hs_w)) check("b_early", 32'(S_AXI_BVALID), 32'd0);
      step();
      cyc++;
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("wr_hs_timeout", 32'(cyc), 32'd0);
      return;
    end
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    exp_upd = 4'b0000;
    if (slot < 4) begin
      model_cfg[slot] = (model_cfg[slot] & ~mask) | (data & mask);
      exp_upd = 4'b0001 << slot;
    end
    $display("[TB] write addr=%h data=%h strb=%h aw_dly=%0d w_dly=%0d b_dly=%0d", addr, data, strb, aw_dly, w_dly, b_dly);
    check("bvalid", 32'(S_AXI_BVALID), 32'd1);
    check("bresp", 32'(S_AXI_BRESP), 32'd0);
    check("cfg_upd", 32'(cfg_upd), 32'(exp_upd));
    check_all_cfg("cfg_reg_wr");
    for (int i = 0; i < b_dly; i++) begin
      step();
      check("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      check("awready_blk", 32'(S_AXI_AWREADY), 32'd0);
      check("wready_blk", 32'(S_AXI_WREADY), 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    check("bvalid_clr", 32'(S_AXI_BVALID), 32'd0);
    check("upd_width", 32'(cfg_upd), 32'd0);
    check("awready_back", 32'(S_AXI_AWREADY), 32'd1);
    check("wready_back", 32'(S_AXI_WREADY), 32'd1);
  endtask

  task automatic do_read(input logic [4:0] addr, input int ar_dly, input int r_dly);
    bit done = 0;
    int cyc = 0;
    logic [31:0] exp = '0;
    while (!done && cyc < 50) begin
      S_AXI_ARVALID = cyc >= ar_dly;
      S_AXI_ARADDR  = addr;
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        done = 1;
        exp = model_read(addr);
      end
      step();
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!done) begin
      check("rd_hs_timeout", 32'(cyc), 32'd0);
      return;
    end
    $display("[TB] read  addr=%h expect=%h ar_dly=%0d r_dly=%0d", addr, exp, ar_dly, r_dly);
    check("rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("rdata", S_AXI_RDATA, exp);
    check("rresp", 32'(S_AXI_RRESP), 32'd0);
    check("arready_busy", 32'(S_AXI_ARREADY), 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      sts_lost_cnt  = $urandom;
      sts_frame_cnt = $urandom;
      step();
      check("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
      check("rdata_hold", S_AXI_RDATA, exp);
    end
    S_AXI_RREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0;
    check("rvalid_clr", 32'(S_AXI_RVALID), 32'd0);
    check("arready_back", 32'(S_AXI_ARREADY), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'd0);
    check({tag, "_wready"}, 32'(S_AXI_WREADY), 32'd0);
    check({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd0);
    check({tag, "_bvalid"}, 32'(S_AXI_BVALID), 32'd0);
    check({tag, "_rvalid"}, 32'(S_AXI_RVALID), 32'd0);
    check({tag, "_rdata"}, S_AXI_RDATA, 32'd0);
    check({tag, "_upd"}, 32'(cfg_upd), 32'd0);
    check_all_cfg({tag, "_cfg"});
  endtask

  initial begin
    for (int k = 0; k < 4; k++) model_cfg[k] = '0;
    step();
    step();
    check_reset_outputs("rst");
    ARESET = 1'b0;
    step();
    check("rst_awready_rise", 32'(S_AXI_AWREADY), 32'd1);
    check("rst_arready_rise", 32'(S_AXI_ARREADY), 32'd1);

    // sequential full-word writes then readback
    for (int k = 0; k < 4; k++) do_write(5'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
    for (int k = 0; k < 4; k++) do_read(5'(4 * k), 0, 0);

    // partial strobes
    do_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(5'h04, 32'h11223344, 4'b0101, 0, 0, 0);
    do_read(5'h04, 0, 0);
    check("strobe_merge", cfg_reg1, 32'hAA22CC44);

    // AW leading W and W leading AW
    do_write(5'h08, 32'h5A5A0001, 4'hF, 0, 3, 0);
    do_write(5'h0C, 32'hA5A50002, 4'hF, 3, 0, 0);

    // B back-pressure followed by a second write
    do_write(5'h00, 32'hDEAD0001, 4'hF, 0, 0, 5);
    do_write(5'h00, 32'hDEAD0002, 4'hF, 0, 0, 0);

    // status and reserved slots
    sts_lost_cnt = 32'h0000002A;
    do_read(5'h10, 0, 0);
    do_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_read(5'h10, 0, 0);
    do_read(5'h18, 0, 0);
    do_write(5'h1C, 32'h12345678, 4'hF, 1, 0, 1);
    do_read(5'h1C, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [4:0] addr;
      addr = 5'($urandom_range(0, 31));
      sts_lost_cnt  = $urandom;
      sts_frame_cnt = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(addr, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // reset between AW and W handshakes
    S_AXI_AWADDR  = 5'h00;
    S_AXI_AWVALID = 1'b1;
    step();
    S_AXI_AWVALID = 1'b0;
    #2;
    ARESET = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) model_cfg[k] = '0;
    check_reset_outputs("midrst");
    step();
    ARESET = 1'b0;
    step();
    check("midrst_awready_rise", 32'(S_AXI_AWREADY), 32'd1);
    check("midrst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    do_write(5'h00, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(5'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/plc_axil_regs.md
# plc_axil_regs

AXI4-Lite slave register file for the PLC (packet-loss-concealment) IP. It is the stage directly downstream of the AXI4-Lite master (PS or bench VIP): it accepts 32-bit single-beat writes and reads and exposes four R/W configuration words to the PLC core. It also exposes two read-only status words from the core. Accepted writes are reported to the core with per-register update strobes.

## Interface

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte-address width; 8 word slots.

Ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  5  write address (byte).
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  5  read address (byte).
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- cfg_reg0..cfg_reg3  out  32 each  current values of word slots 0–3.
- cfg_upd  out  4  one-cycle pulse, bit k set in the cycle after slot k is written.
- sts_lost_cnt  in  32  core status, read at slot 4 (0x10).
- sts_frame_cnt  in  32  core status, read at slot 5 (0x14).

## Operation

- Word index = ADDR[4:2]; ADDR[1:0] ignored.
- Slots 0–3 are R/W: byte lane b is written only if WSTRB[b] = 1.
- Slots 4–5 are read-only: reads return the status input sampled at the AR handshake. Writes are accepted with OKAY and have no effect; cfg_upd stays 0.
- Slots 6–7 read 0. Writes to them are discarded with OKAY.
- Write path:
  - AW and W are captured independently into holding registers, each with its own latched flag.
  - AWREADY = !aw_latched && !BVALID, registered. WREADY is the same with w_latched.
  - When both flags are set, the write executes on the next edge: register update, cfg_upd pulse, BVALID = 1, both flags cleared.
  - BVALID holds until BREADY is sampled high. No new AW/W is accepted while BVALID = 1.
- Read path:
  - ARREADY = !RVALID, registered.
  - On the AR handshake, RDATA is loaded and RVALID = 1 on the next edge.
  - RVALID and RDATA hold stable until RREADY is sampled high.
- Read and write channels are independent; both may complete in the same cycle.
- Same-cycle read and write to the same slot: the read returns the pre-write value.
- Unsupported behaviour: bursts, IDs and error responses are not implemented.

## Timing

- Reset (async assert, sync deassert by the system):
  - All outputs are 0, including all cfg_reg and cfg_upd, and every READY.
  - READY outputs rise on the first ACLK edge after ARESET falls.
- Write latency:
  - AW and W both handshaken in cycle N → cfg_regk updated, cfg_upd[k] = 1 and BVALID = 1, all in cycle N+1.
  - AW in cycle N and W in cycle M > N → same results in cycle M+1. The mirrored order (W first) behaves identically.
- Back-to-back writes:
  - With BREADY held high, BVALID clears at the end of cycle N+1.
  - READY rises in N+2, so the next write can start one cycle later.
- Read latency: AR handshake in cycle N → RVALID and RDATA in cycle N+1.
  - With RREADY held high, the read throughput is one read per 2 cycles.
- Reset mid-transaction clears any latched AW/W, BVALID and RVALID immediately. No pending write is committed.
- cfg_upd is exactly one cycle wide. Two consecutive writes to the same slot give two separate pulses.

## Test plan

- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB = 0xF, then reads of the same addresses → read data 0x1..0x4, all BRESP/RRESP = 0. cfg_upd pulses bits 0..3 in order, once each.
- Slot 1 holds 0xAABBCCDD; write 0x11223344 with WSTRB = 4'b0101 → slot 1 reads 0xAA22CC44.
- AW presented 3 cycles before W, and separately W before AW → one register update each. BVALID is asserted one cycle after the later handshake.
- BREADY held low for 5 cycles → BVALID stays high and AWREADY/WREADY stay low throughout. A second write completes only after B is accepted.
- sts_lost_cnt = 0x0000002A, then read 0x10; write 0xFFFFFFFF to 0x10; read 0x18 → 0x2A, then 0x2A again with no cfg_upd pulse, then 0x0.
- Assert ARESET after the AW handshake but before W → all outputs are 0 and cfg_reg values are unchanged from reset (all 0). After release, a write followed by a read of slot 0 works normally.
